// File: rtl/sprite_blitter.sv
// sprite_blitter: pipelined ROM-backed sprite renderer for the VGA path.
// Pixel coordinates flow through a 3-stage pipeline (address, ROM read,
// colour register); position/enable/animation state only change at frame
// start so a frame is never torn.
// Optional feature macro: SPRITE_FLIP_EN adds the flip port (horizontal mirror).

module sprite_blitter #(
  parameter int SPR_W      = 25,
  parameter int SPR_H      = 18,
  parameter int SCALE_LOG2 = 0,
  parameter int FRAMES     = 1,
  parameter int ANIM_DIV   = 8,
  parameter int IDX_W      = 2,
  parameter int TRANS_IDX  = 0,
  localparam int ROM_AW    = $clog2(SPR_W * SPR_H * FRAMES),
  localparam int FI_W      = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              enable,
`ifdef SPRITE_FLIP_EN
  input  logic              flip,
`endif
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pal_index,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              pixel_hit,
  output logic [FI_W-1:0]   frame_idx
);

  localparam int          DIV_W       = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int unsigned BOX_W       = SPR_W << SCALE_LOG2;
  localparam int unsigned BOX_H       = SPR_H << SCALE_LOG2;
  localparam int          FRAME_WORDS = SPR_W * SPR_H;

  logic [9:0]        pos_x_l, pos_y_l;
  logic              enable_l;
  logic [DIV_W-1:0]  div_cnt, div_nx;
  logic [FI_W-1:0]   frame_nx, frame_e;
  logic              frame_start;
  logic [9:0]        pos_x_e, pos_y_e;
  logic              enable_e;
  logic [9:0]        rel_x, rel_y, sx, sy;
  logic              in_box;
  logic [ROM_AW-1:0] sx_e, addr;
  logic              hit1, hit2, blank1, blank2;
`ifdef SPRITE_FLIP_EN
  logic              flip_l, flip_e;
`endif

  assign frame_start = (DrawX == '0) && (DrawY == '0);
  assign pal_index   = rom_q;

  // Animation divider / frame index values to be loaded at the next frame start
  always_comb begin
    div_nx   = div_cnt + 1'b1;
    frame_nx = frame_idx;
    if (div_cnt == DIV_W'(ANIM_DIV - 1)) begin
      div_nx   = '0;
      frame_nx = (frame_idx == FI_W'(FRAMES - 1)) ? '0 : frame_idx + 1'b1;
    end
  end

  // Bypass the shadow registers on the frame-start pixel so the new values
  // already apply to that pixel, matching what the registers hold afterwards.
  always_comb begin
    pos_x_e  = frame_start ? pos_x    : pos_x_l;
    pos_y_e  = frame_start ? pos_y    : pos_y_l;
    enable_e = frame_start ? enable   : enable_l;
    frame_e  = frame_start ? frame_nx : frame_idx;
`ifdef SPRITE_FLIP_EN
    flip_e   = frame_start ? flip     : flip_l;
`endif
  end

  // Stage 0: box test and ROM address formation
  always_comb begin
    rel_x  = DrawX - pos_x_e;
    rel_y  = DrawY - pos_y_e;
    in_box = enable_e && (32'(rel_x) < BOX_W) && (32'(rel_y) < BOX_H);
    sx     = rel_x >> SCALE_LOG2;
    sy     = rel_y >> SCALE_LOG2;
    sx_e   = ROM_AW'(sx);
`ifdef SPRITE_FLIP_EN
    if (flip_e) sx_e = ROM_AW'(SPR_W - 1) - ROM_AW'(sx);
`endif
    addr   = ROM_AW'(frame_e) * ROM_AW'(FRAME_WORDS) + ROM_AW'(sy) * ROM_AW'(SPR_W) + sx_e;
  end

  // Frame-start shadow registers and animation state
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      pos_x_l   <= '0;
      pos_y_l   <= '0;
      enable_l  <= 1'b0;
      div_cnt   <= '0;
      frame_idx <= '0;
`ifdef SPRITE_FLIP_EN
      flip_l    <= 1'b0;
`endif
    end else if (frame_start) begin
      pos_x_l   <= pos_x;
      pos_y_l   <= pos_y;
      enable_l  <= enable;
      div_cnt   <= div_nx;
      frame_idx <= frame_nx;
`ifdef SPRITE_FLIP_EN
      flip_l    <= flip;
`endif
    end
  end

  // Stages 1 and 2: ROM address register and hit/blank alignment with ROM latency
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      rom_addr <= '0;
      hit1     <= 1'b0;
      blank1   <= 1'b0;
      hit2     <= 1'b0;
      blank2   <= 1'b0;
    end else begin
      rom_addr <= in_box ? addr : '0;
      hit1     <= in_box;
      blank1   <= blank;
      hit2     <= hit1;
      blank2   <= blank1;
    end
  end

  // Output register: colour only for opaque sprite pixels in the active area
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      pixel_hit <= 1'b0;
    end else if (blank2 && hit2 && (rom_q != IDX_W'(TRANS_IDX))) begin
      red       <= pal_red;
      green     <= pal_green;
      blue      <= pal_blue;
      pixel_hit <= 1'b1;
    end else begin
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      pixel_hit <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Testbench for sprite_blitter. Two instances share the pixel stream:
//   A: 25x18, scale 1, FRAMES=3, ANIM_DIV=2
//   B: 25x18, scale 4, FRAMES=1, ANIM_DIV=1
// Expected outputs come from a behavioural model and are queued per pixel.

module tb_sprite_blitter;

  logic       vga_clk = 1'b0;
  logic       reset   = 1'b1;
  logic [9:0] DrawX = '0, DrawY = '0, pos_x = '0, pos_y = '0;
  logic       blank = 1'b0, enable = 1'b0;
`ifdef SPRITE_FLIP_EN
  logic       flip = 1'b0;
`endif

  logic [10:0] rom_addr_a;
  logic [1:0]  rom_q_a, pal_index_a, frame_idx_a;
  logic [3:0]  red_a, green_a, blue_a;
  logic        pixel_hit_a;
  logic [11:0] pa;

  logic [8:0]  rom_addr_b;
  logic [1:0]  rom_q_b, pal_index_b;
  logic [0:0]  frame_idx_b;
  logic [3:0]  red_b, green_b, blue_b;
  logic        pixel_hit_b;
  logic [11:0] pb;

  typedef struct {
    logic [12:0] a;
    logic [12:0] b;
    int          x;
    int          y;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // model state
  int   lpx = 0, lpy = 0, mdiv_a = 0, mfr_a = 0;
  logic len = 1'b0, lfl = 1'b0;

  always #5 vga_clk = ~vga_clk;

  function automatic logic [1:0] rom_val(input int a);
    if (a % 9 == 4) return 2'd0;
    return 2'((a % 3) + 1);
  endfunction

  function automatic logic [11:0] pal(input logic [1:0] i);
    return {i, 2'b01, 2'b10, i, ~i, i};
  endfunction

  assign pa = pal(pal_index_a);
  assign pb = pal(pal_index_b);

  always @(posedge vga_clk) begin
    rom_q_a <= rom_val(int'(rom_addr_a));
    rom_q_b <= rom_val(int'(rom_addr_b));
  end

  sprite_blitter #(.SPR_W(25), .SPR_H(18), .SCALE_LOG2(0), .FRAMES(3), .ANIM_DIV(2),
                   .IDX_W(2), .TRANS_IDX(0)) dut_a (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .pos_x(pos_x), .pos_y(pos_y), .enable(enable),
`ifdef SPRITE_FLIP_EN
    .flip(flip),
`endif
    .rom_addr(rom_addr_a), .rom_q(rom_q_a), .pal_index(pal_index_a),
    .pal_red(pa[11:8]), .pal_green(pa[7:4]), .pal_blue(pa[3:0]),
    .red(red_a), .green(green_a), .blue(blue_a), .pixel_hit(pixel_hit_a),
    .frame_idx(frame_idx_a));

  sprite_blitter #(.SPR_W(25), .SPR_H(18), .SCALE_LOG2(2), .FRAMES(1), .ANIM_DIV(1),
                   .IDX_W(2), .TRANS_IDX(0)) dut_b (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .pos_x(pos_x), .pos_y(pos_y), .enable(enable),
`ifdef SPRITE_FLIP_EN
    .flip(flip),
`endif
    .rom_addr(rom_addr_b), .rom_q(rom_q_b), .pal_index(pal_index_b),
    .pal_red(pb[11:8]), .pal_green(pb[7:4]), .pal_blue(pb[3:0]),
    .red(red_b), .green(green_b), .blue(blue_b), .pixel_hit(pixel_hit_b),
    .frame_idx(frame_idx_b));

  function automatic logic [12:0] model_px(input int x, input int y, input logic b,
                                           input int s, input int fr);
    int w, h, sx, sy, a;
    logic [1:0] idx;
    w = 25 << s;
    h = 18 << s;
    if (!(b && len && x >= lpx && x < lpx + w && y >= lpy && y < lpy + h)) return '0;
    sx = (x - lpx) / (1 << s);
    sy = (y - lpy) / (1 << s);
    if (lfl) sx = 24 - sx;
    a = fr * 450 + sy * 25 + sx;
    idx = rom_val(a);
    if (idx == 2'd0) return '0;
    return {1'b1, pal(idx)};
  endfunction

  task automatic model_reset();
    lpx = 0; lpy = 0; len = 1'b0; lfl = 1'b0; mdiv_a = 0; mfr_a = 0;
  endtask

  // Present one pixel, queue its expected outputs, advance one clock.
  task automatic drive(input int x, input int y, input logic b);
    exp_t e;
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = b;
    if (x == 0 && y == 0) begin
      lpx = int'(pos_x);
      lpy = int'(pos_y);
      len = enable;
`ifdef SPRITE_FLIP_EN
      lfl = flip;
`endif
      if (mdiv_a == 1) begin
        mdiv_a = 0;
        mfr_a  = (mfr_a + 1) % 3;
      end else begin
        mdiv_a = mdiv_a + 1;
      end
    end
    e.a = model_px(x, y, b, 0, mfr_a);
    e.b = model_px(x, y, b, 2, 0);
    e.x = x;
    e.y = y;
    sb.push_back(e);
    @(posedge vga_clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sb.delete();
    model_reset();
    @(posedge vga_clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    pos_x = 10'd100; pos_y = 10'd50; enable = 1'b1; blank = 1'b1;
    DrawX = 10'd110; DrawY = 10'd55;
    repeat (2) @(posedge vga_clk);
    #1;
    vectors++;
    if ({pixel_hit_a, red_a, green_a, blue_a, rom_addr_a, frame_idx_a} !== '0) begin
      miscompares++;
      $display("FAIL reset_state_a: got %h want 0", {pixel_hit_a, red_a, green_a, blue_a, rom_addr_a, frame_idx_a});
    end
    vectors++;
    if ({pixel_hit_b, red_b, green_b, blue_b, rom_addr_b, frame_idx_b} !== '0) begin
      miscompares++;
      $display("FAIL reset_state_b: got %h want 0", {pixel_hit_b, red_b, green_b, blue_b, rom_addr_b, frame_idx_b});
    end
    reset = 1'b0;
    model_reset();
    // in-box pixels before any frame start stay hidden, then a frame start shows them
    for (int i = 0; i < 30; i++) begin
      if (i < 6)       drive(105 + i, 55, 1'b1);
      else if (i == 6) drive(0, 0, 1'b1);
      else             drive(95 + i, 55, 1'b1);
      if (sb.size() == 3) begin
        e = sb.pop_front();
        vectors++;
        if ({pixel_hit_a, red_a, green_a, blue_a} !== e.a) begin
          miscompares++;
          $display("FAIL reset_px_a (%0d,%0d): got %h want %h", e.x, e.y, {pixel_hit_a, red_a, green_a, blue_a}, e.a);
        end
        vectors++;
        if ({pixel_hit_b, red_b, green_b, blue_b} !== e.b) begin
          miscompares++;
          $display("FAIL reset_px_b (%0d,%0d): got %h want %h", e.x, e.y, {pixel_hit_b, red_b, green_b, blue_b}, e.b);
        end
      end
    end
    // asynchronous reset mid-line while the sprite is being drawn
    #2 reset = 1'b1;
    sb.delete();
    model_reset();
    for (int i = 0; i < 4; i++) begin
      if (i == 0) #1;
      else begin
        @(posedge vga_clk);
        #1;
      end
      vectors++;
      if ({pixel_hit_a, red_a, green_a, blue_a, pixel_hit_b, red_b, green_b, blue_b} !== '0) begin
        miscompares++;
        $display("FAIL reset_midline: got %h want 0", {pixel_hit_a, red_a, green_a, blue_a, pixel_hit_b, red_b, green_b, blue_b});
      end
    end
    reset = 1'b0;
    for (int x = 100; x < 112; x++) begin
      drive(x, 56, 1'b1);
      if (sb.size() == 3) begin
        e = sb.pop_front();
        vectors++;
        if ({pixel_hit_a, red_a, green_a, blue_a} !== e.a) begin
          miscompares++;
          $display("FAIL reset_hidden_a (%0d,%0d): got %h want %h", e.x, e.y, {pixel_hit_a, red_a, green_a, blue_a}, e.a);
        end
        vectors++;
        if ({pixel_hit_b, red_b, green_b, blue_b} !== e.b) begin
          miscompares++;
          $display("FAIL reset_hidden_b (%0d,%0d): got %h want %h", e.x, e.y, {pixel_hit_b, red_b, green_b, blue_b}, e.b);
        end
      end
    end
  endtask

  task automatic test_placement();
    exp_t e;
    int rows[5] = '{49, 50, 60, 67, 68};
    do_reset();
    pos_x = 10'd100; pos_y = 10'd50; enable = 1'b1;
    drive(0, 0, 1'b1);
    for (int r = 0; r < 5; r++) begin
      for (int x = 98; x <= 126; x++) begin
        drive(x, rows[r], 1'b1);
        if (x == 100 && rows[r] == 50) begin
          vectors++;
          if (rom_addr_a !== 11'd0) begin
            miscompares++;
            $display("FAIL place_addr_first: got %0d want 0", rom_addr_a);
          end
        end
        if (x == 124 && rows[r] == 67) begin
          vectors++;
          if (rom_addr_a !== 11'd449) begin
            miscompares++;
            $display("FAIL place_addr_last: got %0d want 449", rom_addr_a);
          end
        end
        if (sb.size() == 3) begin
          e = sb.pop_front();
          vectors++;
          if ({pixel_hit_a, red_a, green_a, blue_a} !== e.a) begin
            miscompares++;
            $display("FAIL place_a (%0d,%0d): got %h want %h", e.x, e.y, {pixel_hit_a, red_a, green_a, blue_a}, e.a);
          end
          vectors++;
          if ({pixel_hit_b, red_b, green_b, blue_b} !== e.b) begin
            miscompares++;
            $display("FAIL place_b (%0d,%0d): got %h want %h", e.x, e.y, {pixel_hit_b, red_b, green_b, blue_b}, e.b);
          end
        end
      end
    end
  endtask

  task automatic test_scaling();
    exp_t e;
    int px[$], py[$];
    pos_x = 10'd0; pos_y = 10'd0; enable = 1'b1;
    for (int x = 0; x <= 101; x++) begin px.push_back(x); py.push_back(0); end
    for (int x = 95; x <= 101; x++) begin px.push_back(x); py.push_back(71); end
    for (int x = 95; x <= 101; x++) begin px.push_back(x); py.push_back(72); end
    foreach (px[i]) begin
      drive(px[i], py[i], 1'b1);
      if (py[i] == 0 && px[i] <= 4) begin
        vectors++;
        if (rom_addr_b !== 9'((px[i] == 4) ? 1 : 0)) begin
          miscompares++;
          $display("FAIL scale_addr x=%0d: got %0d want %0d", px[i], rom_addr_b, (px[i] == 4) ? 1 : 0);
        end
      end
      if (py[i] == 71 && px[i] == 99) begin
        vectors++;
        if (rom_addr_b !== 9'd449) begin
          miscompares++;
          $display("FAIL scale_addr_corner: got %0d want 449", rom_addr_b);
        end
      end
      if (sb.size() == 3) begin
        e = sb.pop_front();
        vectors++;
        if ({pixel_hit_a, red_a, green_a, blue_a} !== e.a) begin
          miscompares++;
          $display("FAIL scale_a (%0d,%0d): got %h want %h", e.x, e.y, {pixel_hit_a, red_a, green_a, blue_a}, e.a);
        end
        vectors++;
        if ({pixel_hit_b, red_b, green_b, blue_b} !== e.b) begin
          miscompares++;
          $display("FAIL scale_b (%0d,%0d): got %h want %h", e.x, e.y, {pixel_hit_b, red_b, green_b, blue_b}, e.b);
        end
      end
    end
  endtask

  task automatic test_transparency();
    exp_t e;
    pos_x = 10'd100; pos_y = 10'd50; enable = 1'b1;
    for (int i = 0; i < 27; i++) begin
      if (i == 0) drive(0, 0, 1'b1);
      else        drive(99 + ((i - 1) % 13), 50, (i < 14) ? 1'b1 : 1'b0);
      if (sb.size() == 3) begin
        e = sb.pop_front();
        vectors++;
        if ({pixel_hit_a, red_a, green_a, blue_a} !== e.a) begin
          miscompares++;
          $display("FAIL trans_a (%0d,%0d): got %h want %h", e.x, e.y, {pixel_hit_a, red_a, green_a, blue_a}, e.a);
        end
        vectors++;
        if ({pixel_hit_b, red_b, green_b, blue_b} !== e.b) begin
          miscompares++;
          $display("FAIL trans_b (%0d,%0d): got %h want %h", e.x, e.y, {pixel_hit_b, red_b, green_b, blue_b}, e.b);
        end
      end
    end
  endtask

  task automatic test_animation();
    exp_t e;
    int seq[8] = '{0, 0, 1, 1, 2, 2, 0, 0};
    do_reset();
    pos_x = 10'd100; pos_y = 10'd50; enable = 1'b1;
    for (int f = 0; f < 7; f++) begin
      vectors++;
      if (frame_idx_a !== 2'(seq[f]) || frame_idx_b !== 1'b0) begin
        miscompares++;
        $display("FAIL anim_idx frame %0d: got %0d/%0d want %0d/0", f, frame_idx_a, frame_idx_b, seq[f]);
      end
      for (int j = 0; j < 3; j++) begin
        if (j == 0)      drive(0, 0, 1'b1);
        else if (j == 1) drive(100, 50, 1'b1);
        else             drive(101, 51, 1'b1);
        if (j == 1) begin
          vectors++;
          if (rom_addr_a !== 11'(seq[f + 1] * 450)) begin
            miscompares++;
            $display("FAIL anim_base frame %0d: got %0d want %0d", f, rom_addr_a, seq[f + 1] * 450);
          end
        end
        if (sb.size() == 3) begin
          e = sb.pop_front();
          vectors++;
          if ({pixel_hit_a, red_a, green_a, blue_a} !== e.a) begin
            miscompares++;
            $display("FAIL anim_a (%0d,%0d): got %h want %h", e.x, e.y, {pixel_hit_a, red_a, green_a, blue_a}, e.a);
          end
          vectors++;
          if ({pixel_hit_b, red_b, green_b, blue_b} !== e.b) begin
            miscompares++;
            $display("FAIL anim_b (%0d,%0d): got %h want %h", e.x, e.y, {pixel_hit_b, red_b, green_b, blue_b}, e.b);
          end
        end
      end
    end
  endtask

  task automatic test_pos_change();
    exp_t e;
    int px[$], py[$];
    pos_x = 10'd100; pos_y = 10'd50; enable = 1'b1;
    for (int ph = 0; ph < 4; ph++) begin
      px.delete(); py.delete();
      case (ph)
        0: begin
          px.push_back(0); py.push_back(0);
          for (int x = 95; x <= 130; x++) begin px.push_back(x); py.push_back(60); end
        end
        1: begin
          pos_x = 10'd300;
          px.push_back(150); py.push_back(200);
          for (int x = 95; x <= 130; x++) begin px.push_back(x); py.push_back(60); end
        end
        2: begin
          px.push_back(0); py.push_back(0);
          for (int x = 295; x <= 330; x++) begin px.push_back(x); py.push_back(60); end
          for (int x = 95; x <= 105; x++) begin px.push_back(x); py.push_back(60); end
        end
        default: begin
          enable = 1'b0;
          for (int x = 295; x <= 305; x++) begin px.push_back(x); py.push_back(60); end
          px.push_back(0); py.push_back(0);
          for (int x = 295; x <= 305; x++) begin px.push_back(x); py.push_back(60); end
          repeat (3) begin px.push_back(799); py.push_back(524); end
        end
      endcase
      foreach (px[i]) begin
        drive(px[i], py[i], (px[i] == 799) ? 1'b0 : 1'b1);
        if ((ph == 1 && px[i] == 100 && py[i] == 60) || (ph == 2 && px[i] == 300)) begin
          vectors++;
          if (rom_addr_a !== 11'(mfr_a * 450 + 250)) begin
            miscompares++;
            $display("FAIL move_addr phase %0d: got %0d want %0d", ph, rom_addr_a, mfr_a * 450 + 250);
          end
        end
        if (sb.size() == 3) begin
          e = sb.pop_front();
          vectors++;
          if ({pixel_hit_a, red_a, green_a, blue_a} !== e.a) begin
            miscompares++;
            $display("FAIL move_a (%0d,%0d): got %h want %h", e.x, e.y, {pixel_hit_a, red_a, green_a, blue_a}, e.a);
          end
          vectors++;
          if ({pixel_hit_b, red_b, green_b, blue_b} !== e.b) begin
            miscompares++;
            $display("FAIL move_b (%0d,%0d): got %h want %h", e.x, e.y, {pixel_hit_b, red_b, green_b, blue_b}, e.b);
          end
        end
      end
    end
  endtask

`ifdef SPRITE_FLIP_EN
  task automatic test_flip();
    exp_t e;
    pos_x = 10'd100; pos_y = 10'd50; enable = 1'b1; flip = 1'b1;
    for (int i = 0; i < 35; i++) begin
      if (i == 0)       drive(0, 0, 1'b1);
      else if (i == 1)  drive(100, 50, 1'b1);
      else if (i < 32)  drive(96 + i, 51, 1'b1);
      else              drive(799, 524, 1'b0);
      if (i == 1) begin
        vectors++;
        if (rom_addr_a !== 11'(mfr_a * 450 + 24) || rom_addr_b !== 9'd24) begin
          miscompares++;
          $display("FAIL flip_addr: got %0d/%0d want %0d/24", rom_addr_a, rom_addr_b, mfr_a * 450 + 24);
        end
      end
      if (sb.size() == 3) begin
        e = sb.pop_front();
        vectors++;
        if ({pixel_hit_a, red_a, green_a, blue_a} !== e.a) begin
          miscompares++;
          $display("FAIL flip_a (%0d,%0d): got %h want %h", e.x, e.y, {pixel_hit_a, red_a, green_a, blue_a}, e.a);
        end
        vectors++;
        if ({pixel_hit_b, red_b, green_b, blue_b} !== e.b) begin
          miscompares++;
          $display("FAIL flip_b (%0d,%0d): got %h want %h", e.x, e.y, {pixel_hit_b, red_b, green_b, blue_b}, e.b);
        end
      end
    end
    flip = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_placement();
    test_scaling();
    test_transparency();
    test_animation();
    test_pos_change();
`ifdef SPRITE_FLIP_EN
    test_flip();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Parametrised, pipelined sprite renderer for the VGA path. It places a ROM-backed sprite at a runtime (x, y) position, with integer power-of-two scaling, multi-frame animation and a transparency key. It emits registered 4-bit RGB plus an opaque-hit flag, so a downstream compositor can layer it over backgrounds. Position and control are sampled once per frame, so the sprite never tears mid-frame.

## Interface
Parameters:
- SPR_W, 25, sprite width in source pixels
- SPR_H, 18, sprite height in source pixels
- SCALE_LOG2, 0, on-screen scale factor 2^SCALE_LOG2 (0..3)
- FRAMES, 1, animation frames stored back-to-back in ROM
- ANIM_DIV, 8, video frames per animation step (>=1)
- IDX_W, 2, palette index width
- TRANS_IDX, 0, palette index treated as transparent
- ROM_AW, $clog2(SPR_W*SPR_H*FRAMES), ROM address width (localparam)

Ports:
- vga_clk  in  1  pixel clock; all logic on posedge
- reset  in  1  asynchronous, active-high
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- blank  in  1  1 = active display area
- pos_x  in  10  sprite top-left column (sampled at frame start)
- pos_y  in  10  sprite top-left row (sampled at frame start)
- enable  in  1  sprite visible (sampled at frame start)
- flip  in  1  horizontal mirror (sampled at frame start; present only with SPRITE_FLIP_EN)
- rom_addr  out  ROM_AW  registered ROM read address
- rom_q  in  IDX_W  ROM data, synchronous read, valid one cycle after rom_addr
- pal_index  out  IDX_W  palette lookup index (= rom_q)
- pal_red, pal_green, pal_blue  in  4 each  combinational palette result for pal_index
- red, green, blue  out  4 each  registered pixel colour
- pixel_hit  out  1  registered; 1 = opaque sprite pixel this cycle
- frame_idx  out  $clog2(FRAMES) (min 1)  current animation frame

## Operation
- Frame start: the cycle with DrawX==0 && DrawY==0. On that edge:
  - pos_x, pos_y, enable and flip are latched into shadow registers.
  - div_cnt increments. When div_cnt reaches ANIM_DIV-1 it wraps to 0 and frame_idx advances mod FRAMES.
- Stage 0 (combinational from inputs):
  - rel_x = DrawX - pos_x_l and rel_y = DrawY - pos_y_l, both 10-bit unsigned with wrap.
  - in_box = enable_l && rel_x < (SPR_W<<SCALE_LOG2) && rel_y < (SPR_H<<SCALE_LOG2).
  - Because the compare is unsigned, a pixel left of or above the sprite wraps to a large value and is correctly out of box.
  - sx = rel_x>>SCALE_LOG2 and sy = rel_y>>SCALE_LOG2.
  - addr = frame_idx*SPR_W*SPR_H + sy*SPR_W + sx. Products use constant multipliers and are sized to ROM_AW without truncating any legal address.
- Stage 1 register: rom_addr <= addr when in_box, else 0. hit1 <= in_box and blank1 <= blank.
- Stage 2 register: hit2 <= hit1 and blank2 <= blank1. rom_q is valid in this stage; pal_index = rom_q.
- Output register:
  - If blank2 && hit2 && rom_q != TRANS_IDX: red/green/blue <= pal_*, and pixel_hit <= 1.
  - Otherwise: red/green/blue <= 0, and pixel_hit <= 0.
- Sprite clipping at the right or bottom screen edge is implicit; no wrap to the opposite edge is drawn.
- Reset (any time, including mid-line):
  - Cleared to 0: red, green, blue, pixel_hit, rom_addr, hit1/2, blank1/2, shadow registers, div_cnt, frame_idx.
  - The sprite stays hidden until the first frame start after reset deasserts.

## Timing
- Latency from DrawX/DrawY/blank to red/green/blue/pixel_hit: 3 cycles, fixed. The upstream sync generator delays hs/vs by 3 to match.
- rom_addr appears 1 cycle after the pixel coordinates, and the ROM returns data 1 cycle later.
- Shadow-register updates take effect for the pixel at frame start itself: the stage-0 compare on that cycle uses the newly latched values.
- frame_idx changes only on a frame-start edge. A frame never mixes two animation frames.
- FRAMES=1: frame_idx is held at 0. ANIM_DIV=1: frame_idx advances every video frame.

## Configuration
- SPRITE_FLIP_EN defined:
  - The flip port exists and is latched at frame start.
  - When flip_l=1, sx is replaced by SPR_W-1-sx before address formation.
- Not defined:
  - No flip port and no flip logic.
  - The address always uses sx directly.

## Test plan
- Reset and idle: assert reset mid-line with enable=1 -> all outputs 0 during reset; pixel_hit stays 0 until one frame start after release.
- Placement: SPR_W=25, SPR_H=18, pos=(100,50), scale 0 -> pixel_hit=1 exactly for DrawX 100..124 and DrawY 50..67. rom_addr=0 at (100,50) and 449 at (124,67), each seen 3 cycles later on the outputs.
- Scaling: SCALE_LOG2=2, pos=(0,0) -> DrawX 0..3 all map to sx=0; box ends at DrawX 99 / DrawY 71; DrawX 100 gives pixel_hit=0.
- Transparency and blank: ROM word = TRANS_IDX inside box -> pixel_hit=0 and RGB=0. An opaque word with blank=0 -> RGB=0.
- Animation: FRAMES=3, ANIM_DIV=2, run 7 frames -> frame_idx sequence 0,0,1,1,2,2,0. The address base for frame 2 is 900.
- Position change mid-frame and flip (with SPRITE_FLIP_EN): change pos_x at DrawY=200 -> the box moves only from the next frame. Flip=1 at (pos_x, pos_y) -> rom_addr = frame base + 24.
